edge_bbox_tracker: RTL and testbench

Downstream consumer of the filter chain's binary edge output (ProcessOut), sampled against the same video timing. Accumulates, over one frame, the bounding box and population count of edge pixels. Publishes the box once per frame for the guitar-note/target locator software to read. Purely streaming: no frame storage, one pixel per clock.

---
 rtl/edge_bbox_tracker.sv | 113 +++++++++++
 tb/tb_edge_bbox_tracker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/edge_bbox_tracker.sv
// edge_bbox_tracker: per-frame bounding box and population count of binary edge pixels
module edge_bbox_tracker #(
  parameter int X_BITS    = 11,
  parameter int Y_BITS    = 11,
  parameter int CNT_BITS  = 20,
  parameter int MIN_COUNT = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                VSync,
  input  logic                HSync,
  input  logic                VDE,
  input  logic                EdgeIn,
  output logic [X_BITS-1:0]   XMin,
  output logic [X_BITS-1:0]   XMax,
  output logic [Y_BITS-1:0]   YMin,
  output logic [Y_BITS-1:0]   YMax,
  output logic [CNT_BITS-1:0] Count,
  output logic                Found,
  output logic                Valid
);
  typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;
  state_t state, state_nx;
  logic vs_d, vde_d, vs_rise, vde_fall, hit, take, clr, report;
  logic hsync_unused;
  logic [X_BITS-1:0] x, min_x, max_x, bmin_x, bmax_x, min_x_nx, max_x_nx;
  logic [Y_BITS-1:0] y, min_y, max_y, bmin_y, bmax_y, min_y_nx, max_y_nx;
  logic [CNT_BITS-1:0] cnt, bcnt, cnt_nx;
  assign hsync_unused = HSync;
  assign vs_rise = VSync & ~vs_d;
  assign vde_fall = vde_d & ~VDE;
  assign hit = VDE & EdgeIn;
  // state register and sync edge history
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      vs_d <= 1'b0;
      vde_d <= 1'b0;
    end else begin
      state <= state_nx;
      vs_d <= VSync;
      vde_d <= VDE;
    end
  end
  // next state; a partial frame after reset is dropped, every later VSync rise closes a frame
  always_comb begin
    state_nx = state == IDLE ? (vs_rise ? ACTIVE : IDLE) : (vs_rise ? REPORT : ACTIVE);
    report = state == REPORT;
    clr = state != ACTIVE;
    take = hit & (state != IDLE);
  end
  // pixel coordinates: x runs along active pixels, y counts completed lines since the frame boundary
  always_ff @(posedge CLK) begin
    if (RST) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= VDE ? x + 1'b1 : '0;
      y <= (vs_rise || report) ? '0 : vde_fall ? y + 1'b1 : y;
    end
  end
  // accumulator update; a pixel arriving in the report cycle seeds the new frame
  always_comb begin
    bmin_x = clr ? '1 : min_x;
    bmax_x = clr ? '0 : max_x;
    bmin_y = clr ? '1 : min_y;
    bmax_y = clr ? '0 : max_y;
    bcnt = clr ? '0 : cnt;
    min_x_nx = (take && x < bmin_x) ? x : bmin_x;
    max_x_nx = (take && x > bmax_x) ? x : bmax_x;
    min_y_nx = (take && y < bmin_y) ? y : bmin_y;
    max_y_nx = (take && y > bmax_y) ? y : bmax_y;
    cnt_nx = (take && !(&bcnt)) ? bcnt + 1'b1 : bcnt;
  end
  // accumulator registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      min_x <= '1;
      max_x <= '0;
      min_y <= '1;
      max_y <= '0;
      cnt <= '0;
    end else begin
      min_x <= min_x_nx;
      max_x <= max_x_nx;
      min_y <= min_y_nx;
      max_y <= max_y_nx;
      cnt <= cnt_nx;
    end
  end
  // publish the closed frame; an empty frame reports a zero box rather than the sentinel
  always_ff @(posedge CLK) begin
    if (RST) begin
      XMin <= '0;
      XMax <= '0;
      YMin <= '0;
      YMax <= '0;
      Count <= '0;
      Found <= 1'b0;
      Valid <= 1'b0;
    end else begin
      Valid <= report;
      if (report) begin
        XMin <= |cnt ? min_x : '0;
        XMax <= |cnt ? max_x : '0;
        YMin <= |cnt ? min_y : '0;
        YMax <= |cnt ? max_y : '0;
        Count <= cnt;
        Found <= 32'(cnt) >= MIN_COUNT;
      end
    end
  end
endmodule

// File: tb/tb_edge_bbox_tracker.sv
// tb_edge_bbox_tracker: randomized frames against a coordinate-level model, scoreboarded reports
module tb_edge_bbox_tracker;
  logic clk = 1'b0, rst = 1'b1, vsync = 1'b0, hsync = 1'b0, vde = 1'b0, edge_in = 1'b0;
  logic [10:0] xmin, xmax, ymin, ymax, xmin4, xmax4, ymin4, ymax4;
  logic [19:0] count;
  logic [3:0] count4;
  logic found, valid, found4, valid4;
  int cyc = 0;
  int checks = 0, passed = 0;
  typedef struct packed {int xmin; int xmax; int ymin; int ymax; int cnt; int found; int at;} rep_t;
  rep_t q_big[$], q_small[$];
  rep_t got_b, got_s;
  int mcnt, mxmin, mxmax, mymin, mymax, last_h;
  bit armed, pvs;

  edge_bbox_tracker dut (
    .CLK(clk), .RST(rst), .VSync(vsync), .HSync(hsync), .VDE(vde), .EdgeIn(edge_in),
    .XMin(xmin), .XMax(xmax), .YMin(ymin), .YMax(ymax), .Count(count), .Found(found), .Valid(valid)
  );
  edge_bbox_tracker #(.CNT_BITS(4), .MIN_COUNT(8)) dut4 (
    .CLK(clk), .RST(rst), .VSync(vsync), .HSync(hsync), .VDE(vde), .EdgeIn(edge_in),
    .XMin(xmin4), .XMax(xmax4), .YMin(ymin4), .YMax(ymax4), .Count(count4), .Found(found4), .Valid(valid4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void mclear();
    mcnt = 0;
    mxmin = 1 << 30;
    mxmax = -1;
    mymin = 1 << 30;
    mymax = -1;
  endfunction

  function automatic rep_t expect_rep(int sat, int minc, int at);
    rep_t r;
    int c = mcnt > sat ? sat : mcnt;
    r.xmin = mcnt > 0 ? mxmin : 0;
    r.xmax = mcnt > 0 ? mxmax : 0;
    r.ymin = mcnt > 0 ? mymin : 0;
    r.ymax = mcnt > 0 ? mymax : 0;
    r.cnt = c;
    r.found = (c >= minc) ? 1 : 0;
    r.at = at;
    return r;
  endfunction

  function automatic bit noise();
    return ($urandom & 1) == 1;
  endfunction

  task automatic cmp(string nm, rep_t g, rep_t e);
    checks++;
    if (g == e) passed++;
    else $display("FAIL %s report: got x %0d..%0d y %0d..%0d count %0d found %0d cycle %0d, required x %0d..%0d y %0d..%0d count %0d found %0d cycle %0d",
                  nm, g.xmin, g.xmax, g.ymin, g.ymax, g.cnt, g.found, g.at, e.xmin, e.xmax, e.ymin, e.ymax, e.cnt, e.found, e.at);
  endtask

  task automatic chk_zero(string nm);
    checks++;
    if ({xmin, xmax, ymin, ymax, count, found, valid, xmin4, xmax4, ymin4, ymax4, count4, found4, valid4} == '0) passed++;
    else $display("FAIL %s: got x %0d..%0d y %0d..%0d count %0d found %0d valid %0d small count %0d valid %0d, required all 0",
                  nm, xmin, xmax, ymin, ymax, count, found, valid, count4, valid4);
  endtask

  task automatic tick(bit vs, bit de, bit e, int x, int y);
    vsync = vs;
    vde = de;
    edge_in = e;
    hsync = !de && !vs;
    if (!rst) begin
      if (de && e) begin
        mcnt++;
        mxmin = x < mxmin ? x : mxmin;
        mxmax = x > mxmax ? x : mxmax;
        mymin = y < mymin ? y : mymin;
        mymax = y > mymax ? y : mymax;
      end
      if (vs && !pvs) begin
        if (armed) begin
          q_big.push_back(expect_rep(1048575, 16, cyc + 2));
          q_small.push_back(expect_rep(15, 8, cyc + 2));
        end
        armed = 1'b1;
        mclear();
      end
    end
    pvs = vs;
    @(posedge clk);
    #1;
  endtask

  function automatic bit pix(int mode, int xx, int yy, int a0, int a1, int b0, int b1, int dens);
    if (mode == 0) return $urandom_range(0, 99) < dens;
    if (mode == 1) return xx >= a0 && xx <= a1 && yy >= b0 && yy <= b1;
    return 1'b0;
  endfunction

  task automatic frame(int w, int h, int mode, int vs_len, bit coin, int a0 = 0, int a1 = 0, int b0 = 0, int b1 = 0, int dens = 0);
    for (int i = 0; i < vs_len; i++) tick(1'b1, coin && i == 0, coin && i == 0, 0, last_h);
    repeat (3) tick(1'b0, 1'b0, noise(), 0, 0);
    for (int yy = 0; yy < h; yy++) begin
      repeat (4) tick(1'b0, 1'b0, noise(), 0, 0);
      for (int xx = 0; xx < w; xx++) tick(1'b0, 1'b1, pix(mode, xx, yy, a0, a1, b0, b1, dens), xx, yy);
    end
    repeat (2) tick(1'b0, 1'b0, noise(), 0, 0);
    last_h = h;
  endtask

  always @(negedge clk) if (valid) begin
    got_b = '{xmin: int'(xmin), xmax: int'(xmax), ymin: int'(ymin), ymax: int'(ymax), cnt: int'(count), found: int'(found), at: cyc};
    if (q_big.size() == 0) begin
      checks++;
      $display("FAIL big unexpected_valid at cycle %0d: got Valid=1, required 0", cyc);
    end else cmp("big", got_b, q_big.pop_front());
  end

  always @(negedge clk) if (valid4) begin
    got_s = '{xmin: int'(xmin4), xmax: int'(xmax4), ymin: int'(ymin4), ymax: int'(ymax4), cnt: int'(count4), found: int'(found4), at: cyc};
    if (q_small.size() == 0) begin
      checks++;
      $display("FAIL small unexpected_valid at cycle %0d: got Valid=1, required 0", cyc);
    end else cmp("small", got_s, q_small.pop_front());
  end

  initial begin
    mclear();
    armed = 1'b0;
    pvs = 1'b0;
    last_h = 0;
    repeat (3) tick(1'b0, 1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    chk_zero("reset_initial");
    frame(20, 6, 0, 2, 1'b0, 0, 0, 0, 0, 40);
    frame(24, 8, 0, 3, 1'b0, 0, 0, 0, 0, 60);
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 1'b0, 0, 0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 0, 0);
    for (int yy = 0; yy < 2; yy++) begin
      repeat (4) tick(1'b0, 1'b0, noise(), 0, 0);
      for (int xx = 0; xx < 32; xx++) tick(1'b0, 1'b1, noise(), xx, yy);
    end
    for (int xx = 0; xx < 10; xx++) tick(1'b0, 1'b1, 1'b1, xx, 2);
    rst = 1'b1;
    repeat (3) tick(1'b0, 1'b1, 1'b1, 0, 0);
    rst = 1'b0;
    armed = 1'b0;
    mclear();
    chk_zero("reset_midline");
    for (int xx = 0; xx < 20; xx++) tick(1'b0, 1'b1, 1'b1, xx, 0);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 0, 0);
    frame(128, 56, 1, 2, 1'b0, 100, 100, 50, 50);
    frame(240, 32, 1, 2, 1'b0, 200, 219, 10, 29);
    frame(40, 12, 2, 3, 1'b0);
    frame(24, 8, 1, 10, 1'b0, 3, 7, 2, 5);
    frame(16, 6, 1, 4, 1'b0, 0, 15, 0, 5);
    for (int f = 0; f < 8; f++)
      frame($urandom_range(8, 40), $urandom_range(4, 16), 0, $urandom_range(1, 12), $urandom_range(0, 2) == 0,
            0, 0, 0, 0, $urandom_range(0, 100));
    frame(8, 2, 2, 2, 1'b1);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 0, 0);
    checks++;
    if (q_big.size() == 0) passed++;
    else $display("FAIL big pending_reports: got %0d outstanding, required 0", q_big.size());
    checks++;
    if (q_small.size() == 0) passed++;
    else $display("FAIL small pending_reports: got %0d outstanding, required 0", q_small.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
